// File: rtl/uart_cmd_dispatcher.sv
// uart_cmd_dispatcher
//   Owns the UART RX byte handshake and parses motor command frames of the
//   form <letter><decimal digits><'#'|'!'>. A frame updates one motor channel:
//   its speed, its direction ('#' = forward, '!' = reverse) and a one-cycle
//   update strobe. Malformed, overflowing or stalled frames raise a one-cycle
//   ERR pulse and bump a saturating error counter.
//
//   Each taken byte is registered first. It is decoded in the following cycle,
//   which is also the cycle rdy_clr is high. A committing frame therefore
//   shows UPDATE two cycles after its terminator is taken.
//
//   Build option:
//     UART_CMD_SAT_CLAMP_EN  defined   : an overflowing frame commits MAX_VAL,
//                                        with no error.
//                            undefined : an overflowing frame is rejected as
//                                        an error.
//
//   Ports:
//     CLOCK_50  in   system clock, rising edge
//     RESET     in   synchronous active-high reset
//     rdy       in   UART RX byte valid
//     dout      in   UART RX byte
//     rdy_clr   out  one-cycle acknowledge, high the cycle after a byte is taken
//     SPEED     out  channel i speed in bits [8i+7:8i]
//     DIR       out  channel i direction, 1 = forward
//     UPDATE    out  one-cycle one-hot strobe when a channel commits
//     ERR       out  one-cycle pulse per frame error
//     ERR_CNT   out  saturating frame error count
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for a channel letter; any other byte is dropped
//   S_DIGITS | collecting digits; idle timeout armed
//   S_COMMIT | single cycle: write SPEED/DIR for r_ch, pulse UPDATE

module uart_cmd_dispatcher #(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] LETTER_BASE = 8'd65,
    parameter int         MAX_VAL     = 255,
    parameter int         TIMEOUT_CYC = 5000000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  rdy,
    input  logic [7:0]            dout,
    output logic                  rdy_clr,
    output logic [8*NUM_CH-1:0]   SPEED,
    output logic [NUM_CH-1:0]     DIR,
    output logic [NUM_CH-1:0]     UPDATE,
    output logic                  ERR,
    output logic [7:0]            ERR_CNT
);

    localparam int              CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      MAX_ACC = 8'(MAX_VAL);
    localparam logic [11:0]     MAX_SUM = 12'(MAX_VAL);

`ifdef UART_CMD_SAT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIGITS = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_rdy_clr;
    logic [7:0]           r_byte;
    logic [CHW-1:0]       r_ch;
    logic [7:0]           r_acc;
    logic                 r_dig_seen;
    logic                 r_ovf;
    logic                 r_fwd;
    logic [TW-1:0]        r_to_cnt;
    logic [8*NUM_CH-1:0]  r_speed;
    logic [NUM_CH-1:0]    r_dir;
    logic                 r_err;
    logic [7:0]           r_err_cnt;

    logic                 w_take;
    logic [8:0]           w_off;
    logic                 w_is_letter;
    logic                 w_is_digit;
    logic                 w_is_term;
    logic [11:0]          w_sum;
    logic                 w_err_evt;
    logic                 w_start;
    logic                 w_add;
    logic                 w_term;
    logic [NUM_CH-1:0]    w_update;

    // rdy_clr doubles as "r_byte holds an undecoded byte"; it also blocks the
    // next take, which limits throughput to one byte every two cycles.
    assign w_take = rdy && !r_rdy_clr && (r_state == S_IDLE || r_state == S_DIGITS);

    // Out-of-range letters, including bytes below LETTER_BASE, give a large
    // unsigned offset and fail the compare.
    assign w_off       = {1'b0, r_byte} - {1'b0, LETTER_BASE};
    assign w_is_letter = (w_off < 9'(NUM_CH));
    assign w_is_digit  = (r_byte >= 8'h30) && (r_byte <= 8'h39);
    assign w_is_term   = (r_byte == 8'h23) || (r_byte == 8'h21);
    // The low nibble of an ASCII digit is its value; 255*10+9 fits in 12 bits.
    assign w_sum       = ({4'd0, r_acc} * 12'd10) + {8'd0, r_byte[3:0]};

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        w_start     = 1'b0;
        w_add       = 1'b0;
        w_term      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rdy_clr && w_is_letter) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DIGITS;
                end
            end
            S_DIGITS: begin
                if (r_rdy_clr) begin
                    if (w_is_digit) begin
                        w_add = 1'b1;
                    end else if (w_is_term) begin
                        if (r_dig_seen && (!r_ovf || CLAMP_EN)) begin
                            w_term      = 1'b1;
                            w_state_nxt = S_COMMIT;
                        end else begin
                            w_err_evt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_is_letter) begin
                        // Abort the current frame; the letter opens a new one.
                        w_err_evt = 1'b1;
                        w_start   = 1'b1;
                    end else begin
                        w_err_evt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_evt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_update = '0;
        if (r_state == S_COMMIT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_ch == CHW'(i)) begin
                    w_update[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_rdy_clr  <= 1'b0;
            r_byte     <= '0;
            r_ch       <= '0;
            r_acc      <= '0;
            r_dig_seen <= 1'b0;
            r_ovf      <= 1'b0;
            r_fwd      <= 1'b0;
            r_to_cnt   <= '0;
            r_speed    <= '0;
            r_dir      <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_rdy_clr <= w_take;
            if (w_take) begin
                r_byte <= dout;
            end

            if (w_start) begin
                r_ch       <= w_off[CHW-1:0];
                r_acc      <= '0;
                r_dig_seen <= 1'b0;
                r_ovf      <= 1'b0;
            end else if (w_add) begin
                r_dig_seen <= 1'b1;
                if (w_sum > MAX_SUM) begin
                    r_acc <= MAX_ACC;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_sum[7:0];
                end
            end

            if (w_term) begin
                r_fwd <= (r_byte == 8'h23);
            end

            // The counter saturates at its terminal value, so it cannot wrap
            // while the timeout error is being raised.
            if (r_state != S_DIGITS || w_take) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if (r_state == S_COMMIT) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_ch == CHW'(i)) begin
                        r_speed[8*i +: 8] <= r_acc;
                        r_dir[i]          <= r_fwd;
                    end
                end
            end

            r_err <= w_err_evt;
            if (w_err_evt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign rdy_clr = r_rdy_clr;
    assign SPEED   = r_speed;
    assign DIR     = r_dir;
    assign UPDATE  = w_update;
    assign ERR     = r_err;
    assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
`timescale 1ns/1ps
module tb_uart_cmd_dispatcher;

    localparam int NUM_CH = 4;
    localparam int TO_CYC = 40;

`ifdef UART_CMD_SAT_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdy = 1'b0;
    logic [7:0]           dout = 8'd0;
    logic                 rdy_clr;
    logic [8*NUM_CH-1:0]  speed;
    logic [NUM_CH-1:0]    dir;
    logic [NUM_CH-1:0]    update;
    logic                 err;
    logic [7:0]           err_cnt;

    uart_cmd_dispatcher #(
        .NUM_CH      (NUM_CH),
        .LETTER_BASE (8'd65),
        .MAX_VAL     (255),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .rdy      (rdy),
        .dout     (dout),
        .rdy_clr  (rdy_clr),
        .SPEED    (speed),
        .DIR      (dir),
        .UPDATE   (update),
        .ERR      (err),
        .ERR_CNT  (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               upd_cnt [NUM_CH] = '{default: 0};
    int               err_pulses   = 0;
    int               clr_pulses   = 0;
    int               multi_upd    = 0;
    int               last_upd_cyc = 0;
    logic [NUM_CH-1:0] last_upd    = '0;

    always @(negedge clk) begin
        if (update != '0) begin
            last_upd     <= update;
            last_upd_cyc <= cyc;
            if (!$onehot(update)) multi_upd <= multi_upd + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (update[i]) upd_cnt[i] <= upd_cnt[i] + 1;
            end
        end
        if (err)     err_pulses <= err_pulses + 1;
        if (rdy_clr) clr_pulses <= clr_pulses + 1;
    end

    int checks     = 0;
    int failures   = 0;
    int bytes_sent = 0;
    int term_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rdy is held for two edges: the second falls while rdy_clr is high and
    // must be ignored, so each call should yield exactly one take.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dout     = b;
        rdy      = 1'b1;
        term_cyc = cyc;
        bytes_sent++;
        @(posedge clk);
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);
    endtask

    int exp_err   = 0;
    int exp_upd   = 0;
    int err_base  = 0;

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        check("rst_speed",   32'(speed),   32'h0);
        check("rst_dir",     32'(dir),     32'h0);
        check("rst_update",  32'(update),  32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_errcnt",  32'(err_cnt), 32'h0);
        check("rst_rdyclr",  32'(rdy_clr), 32'h0);

        send_str("B120#");
        wait_cyc(1);
        check("b120_speed",   32'(speed),   32'h0000_7800);
        check("b120_dir",     32'(dir),     32'b0010);
        check("b120_upd1",    32'(upd_cnt[1]), 32'd1);
        check("b120_onehot",  32'(last_upd), 32'b0010);
        check("b120_latency", 32'(last_upd_cyc - term_cyc), 32'd2);
        check("b120_err",     32'(err_pulses), 32'd0);
        exp_upd = 1;

        // Out-of-range letters and stray bytes in IDLE are dropped silently.
        send_str("aE5#@");
        wait_cyc(1);
        check("drop_upd", 32'(upd_cnt[0] + upd_cnt[1] + upd_cnt[2] + upd_cnt[3]), 32'(exp_upd));
        check("drop_err", 32'(err_pulses), 32'd0);

        send_str("A7!");
        wait_cyc(1);
        check("a7_speed", 32'(speed), 32'h0000_7807);
        check("a7_dir",   32'(dir),   32'b0010);
        send_str("A3#");
        wait_cyc(1);
        check("a3_speed", 32'(speed), 32'h0000_7803);
        check("a3_dir",   32'(dir),   32'b0011);
        check("a_upd0",   32'(upd_cnt[0]), 32'd2);
        exp_upd = 3;

        send_str("C300#");
        wait_cyc(1);
        exp_err = CLAMP ? 0 : 1;
        check("c300_speed",  32'(speed),      CLAMP ? 32'h00FF_7803 : 32'h0000_7803);
        check("c300_dir",    32'(dir),        CLAMP ? 32'b0111 : 32'b0011);
        check("c300_upd2",   32'(upd_cnt[2]), CLAMP ? 32'd1 : 32'd0);
        check("c300_errp",   32'(err_pulses), 32'(exp_err));
        check("c300_errcnt", 32'(err_cnt),    32'(exp_err));

        send_str("C255#");
        wait_cyc(1);
        check("c255_speed", 32'(speed),      32'h00FF_7803);
        check("c255_dir",   32'(dir),        32'b0111);
        check("c255_upd2",  32'(upd_cnt[2]), CLAMP ? 32'd2 : 32'd1);
        check("c255_errp",  32'(err_pulses), 32'(exp_err));

        send_str("A4D9#");
        wait_cyc(1);
        exp_err++;
        check("abort_speed", 32'(speed),      32'h09FF_7803);
        check("abort_dir",   32'(dir),        32'b1111);
        check("abort_upd0",  32'(upd_cnt[0]), 32'd2);
        check("abort_upd3",  32'(upd_cnt[3]), 32'd1);
        check("abort_errp",  32'(err_pulses), 32'(exp_err));
        check("abort_errcnt", 32'(err_cnt),   32'(exp_err));

        send_str("B5");
        wait_cyc(TO_CYC + 20);
        exp_err++;
        check("to_errp",   32'(err_pulses), 32'(exp_err));
        check("to_errcnt", 32'(err_cnt),    32'(exp_err));
        send_str("#");
        wait_cyc(2);
        check("to_drop_upd1", 32'(upd_cnt[1]), 32'd1);
        check("to_drop_errp", 32'(err_pulses), 32'(exp_err));
        check("to_speed",     32'(speed),      32'h09FF_7803);
        check("rdyclr_count", 32'(clr_pulses), 32'(bytes_sent));

        do_reset();
        check("rst2_speed",  32'(speed),   32'h0);
        check("rst2_dir",    32'(dir),     32'h0);
        check("rst2_errcnt", 32'(err_cnt), 32'h0);
        send_str("A#");
        send_str("Ax");
        wait_cyc(1);
        exp_err += 2;
        check("empty_errcnt", 32'(err_cnt),    32'd2);
        check("empty_errp",   32'(err_pulses), 32'(exp_err));
        check("empty_upd0",   32'(upd_cnt[0]), 32'd2);

        send_str("C5");
        do_reset();
        check("midrst_speed",  32'(speed),   32'h0);
        check("midrst_errcnt", 32'(err_cnt), 32'h0);
        send_str("#");
        wait_cyc(2);
        check("midrst_upd2",  32'(upd_cnt[2]), CLAMP ? 32'd2 : 32'd1);
        check("midrst_errp",  32'(err_pulses), 32'(exp_err));
        check("midrst_speed2", 32'(speed),     32'h0);

        err_base = err_pulses;
        for (int k = 0; k < 258; k++) send_str("Ax");
        wait_cyc(1);
        check("sat_errcnt", 32'(err_cnt),               32'd255);
        check("sat_errp",   32'(err_pulses - err_base), 32'd258);
        check("onehot_upd", 32'(multi_upd),             32'd0);
        check("rdyclr_total", 32'(clr_pulses),          32'(bytes_sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_cmd_dispatcher.md
Name: uart_cmd_dispatcher

Overview:
- Sole owner of the UART receiver byte handshake (rdy/dout/rdy_clr).
- Parses framed motor commands of the form <letter><decimal digits><terminator> and routes each to one of NUM_CH motor channels.
- Latches per-channel speed and direction, and pulses a per-channel update strobe.
- Sits between the UART RX block and the PWM/H-bridge drivers, so several motors share one serial link without byte contention.

Parameters:
- NUM_CH, 4, number of motor channels; channel i is selected by letter LETTER_BASE+i.
- LETTER_BASE, 8'd65, ASCII code of channel 0 letter ('A').
- MAX_VAL, 255, largest legal speed value; must fit in 8 bits.
- TIMEOUT_CYC, 5000000, idle cycles allowed between bytes inside a frame (100 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- rdy  in  1  UART RX byte valid.
- dout  in  8  UART RX byte.
- rdy_clr  out  1  one-cycle acknowledge to UART RX.
- SPEED  out  8*NUM_CH  channel i speed in bits [8i+7:8i].
- DIR  out  NUM_CH  channel i direction: 1 = forward ('#'), 0 = reverse ('!').
- UPDATE  out  NUM_CH  one-cycle pulse when channel i SPEED/DIR change is committed.
- ERR  out  1  one-cycle pulse on any frame error.
- ERR_CNT  out  8  saturating count of frame errors.

Behaviour:
- Interface: one clock, CLOCK_50. RESET is synchronous and active-high.
- Reset values: SPEED=0, DIR=0, UPDATE=0, rdy_clr=0, ERR=0, ERR_CNT=0, state=IDLE, accumulator=0, timeout counter=0.
- RESET mid-frame discards the frame with no commit and no error.

Handshake:
- A byte is taken in any cycle where rdy=1, rdy_clr=0 and state is IDLE or DIGITS.
- rdy_clr is registered: it is high exactly the cycle after a byte is taken, otherwise 0.
- rdy is ignored while rdy_clr=1.
- Throughput is at most one byte per 2 cycles.

States and transitions:
- IDLE: a taken byte in [LETTER_BASE, LETTER_BASE+NUM_CH-1] latches the channel index, clears acc and digit count, and moves to DIGITS. Any other byte is dropped silently.
- DIGITS, byte '0'..'9': acc <= acc*10 + (byte-48), computed in 12 bits; digit count +1. If the result exceeds MAX_VAL, set the sticky ovf flag and hold acc at MAX_VAL.
- DIGITS, byte '#' or '!': go to COMMIT if digit count >0 and ovf=0; otherwise go to IDLE with an error.
- DIGITS, valid channel letter: error for the current frame, then a new frame starts for that letter; stay in DIGITS with acc, count and ovf cleared.
- DIGITS, any other byte: error, go to IDLE.
- DIGITS timeout: the counter clears on every taken byte and increments otherwise. When it reaches TIMEOUT_CYC-1: error, go to IDLE.
- COMMIT (1 cycle): SPEED[ch] <= acc, DIR[ch] <= (terminator=='#'), UPDATE[ch]=1 for this cycle only, then go to IDLE.
- Latency: UPDATE rises 2 cycles after the cycle the terminator is taken (registered decode, then COMMIT).

Errors:
- Each error pulses ERR for 1 cycle.
- ERR_CNT increments and saturates at 255.
- A letter-abort followed by a new frame counts as exactly one error.

Other rules:
- Untouched channels hold their values.
- Only one channel commits per frame; UPDATE is one-hot or zero.

Optional Feature:
- Macro: UART_CMD_SAT_CLAMP_EN.
- Defined: overflow does not error. A frame with ovf=1 commits MAX_VAL with the received direction, UPDATE pulses, and ERR stays 0.
- Undefined: overflow frames are rejected as errors, as described above.

Test Plan:
- Reset, then bytes 'B','1','2','0','#' -> SPEED[15:8]=120, DIR[1]=1, UPDATE=4'b0010 for one cycle, ERR=0; other channels stay 0.
- 'A','7','!' then 'A','3','#' -> channel 0 goes to 7/reverse, then 3/forward; two UPDATE[0] pulses; every taken byte gets exactly one rdy_clr pulse the following cycle.
- 'C','3','0','0','#' -> without macro: ERR pulse, ERR_CNT=1, SPEED[23:16] unchanged. With UART_CMD_SAT_CLAMP_EN: SPEED[23:16]=255, UPDATE[2] pulse, ERR=0.
- 'A','4','D','9','#' -> one error for the aborted A frame; channel 3 gets 9/forward; channel 0 unchanged.
- 'B','5', then no bytes for TIMEOUT_CYC cycles -> ERR pulse, state IDLE; a following '#' is dropped with no UPDATE.
- 'A','#' (empty frame) and 'A','x' -> two errors, ERR_CNT=2, no UPDATE. Asserting RESET mid-frame -> all outputs return to 0.
